// File: rtl/alu_result_sink.sv
// Consumer end of the ALU output: valid/ready intake, writeback FIFO, flag register and branch evaluation.
// Optional macro FLAG_FWD_EN: forwards the accepted flags straight to br_taken in the accept cycle.
module alu_result_sink #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_carry,
   input  logic              in_zero,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_wr_en,
   input  logic              in_flag_en,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_AW-1:0] wb_rd,
   output logic              flag_carry,
   output logic              flag_zero,
   output logic              flag_sign,
   input  logic [2:0]        br_cond,
   output logic              br_taken
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [REG_AW-1:0] rd_q   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              carry_q, carry_d;
   logic              zero_q, zero_d;
   logic              sign_q, sign_d;

   logic accept, push, pop, full, empty;
   logic f_carry, f_zero, f_sign;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign in_ready = !full;
   assign wb_valid = !empty;
   assign accept   = in_valid & in_ready;
   assign push     = accept & in_wr_en;
   assign pop      = wb_valid & wb_ready;
   assign wb_data  = data_q[rd_ptr_q];
   assign wb_rd    = rd_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      carry_d = carry_q;
      zero_d  = zero_q;
      sign_d  = sign_q;
      if (accept && in_flag_en) begin
         carry_d = in_carry;
         zero_d  = in_zero;
         sign_d  = in_result[DATA_W-1];
      end
   end

   // Storage is reset too so wb_data/wb_rd are never X, even before the first push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            rd_q[i]   <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         sign_q   <= 1'b0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q] <= in_result;
            rd_q[wr_ptr_q]   <= in_rd;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         sign_q   <= sign_d;
      end
   end

   assign flag_carry = carry_q;
   assign flag_zero  = zero_q;
   assign flag_sign  = sign_q;

`ifdef FLAG_FWD_EN
   assign f_carry = (accept && in_flag_en) ? in_carry             : carry_q;
   assign f_zero  = (accept && in_flag_en) ? in_zero              : zero_q;
   assign f_sign  = (accept && in_flag_en) ? in_result[DATA_W-1]  : sign_q;
`else
   assign f_carry = carry_q;
   assign f_zero  = zero_q;
   assign f_sign  = sign_q;
`endif

   always_comb begin
      br_taken = 1'b0;
      case (br_cond)
         3'd0: br_taken = 1'b0;
         3'd1: br_taken = 1'b1;
         3'd2: br_taken = f_zero;
         3'd3: br_taken = !f_zero;
         3'd4: br_taken = f_carry;
         3'd5: br_taken = !f_carry;
         3'd6: br_taken = f_sign;
         3'd7: br_taken = !f_sign && !f_zero;
         default: br_taken = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_result_sink.sv
// Directed self-checking bench for alu_result_sink (DEPTH=2, DATA_W=32).
module tb_alu_result_sink;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_result;
   logic        in_carry, in_zero;
   logic [4:0]  in_rd;
   logic        in_wr_en, in_flag_en;
   logic        wb_valid, wb_ready;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        flag_carry, flag_zero, flag_sign;
   logic [2:0]  br_cond;
   logic        br_taken;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   alu_result_sink #(.DATA_W(32), .REG_AW(5), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_carry(in_carry), .in_zero(in_zero), .in_rd(in_rd),
      .in_wr_en(in_wr_en), .in_flag_en(in_flag_en),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
      .flag_carry(flag_carry), .flag_zero(flag_zero), .flag_sign(flag_sign),
      .br_cond(br_cond), .br_taken(br_taken)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] res,
                        input logic we, input logic fe, input logic c, input logic z);
      in_valid = v; in_rd = rd; in_result = res; in_wr_en = we;
      in_flag_en = fe; in_carry = c; in_zero = z;
   endtask

   task automatic test_reset();
      total_cnt++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got %b want 0", wb_valid); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
      total_cnt++; if ({flag_carry, flag_zero, flag_sign} !== 3'b000)
         $display("FAIL reset_flags got %b want 000", {flag_carry, flag_zero, flag_sign}); else pass_cnt++;
      total_cnt++; if (wb_data !== 32'd0) $display("FAIL reset_wb_data got %h want 0", wb_data); else pass_cnt++;
      br_cond = 3'd1; #1;
      total_cnt++; if (br_taken !== 1'b1) $display("FAIL reset_br_always got %b want 1", br_taken); else pass_cnt++;
      br_cond = 3'd0; #1;
      total_cnt++; if (br_taken !== 1'b0) $display("FAIL reset_br_never got %b want 0", br_taken); else pass_cnt++;
   endtask

   task automatic test_single_hold();
      wb_ready = 1'b0;
      drive(1'b1, 5'd3, 32'd15, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      total_cnt++; if (wb_valid !== 1'b0) $display("FAIL single_pre_valid got %b want 0", wb_valid); else pass_cnt++;
      cyc();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (wb_valid !== 1'b1) $display("FAIL single_valid got %b want 1", wb_valid); else pass_cnt++;
      total_cnt++; if (wb_rd !== 5'd3) $display("FAIL single_rd got %0d want 3", wb_rd); else pass_cnt++;
      total_cnt++; if (wb_data !== 32'd15) $display("FAIL single_data got %0d want 15", wb_data); else pass_cnt++;
      cyc(); cyc();
      total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'd15)
         $display("FAIL single_hold got v=%b d=%0d want v=1 d=15", wb_valid, wb_data); else pass_cnt++;
      wb_ready = 1'b1;
      cyc();
      wb_ready = 1'b0;
      total_cnt++; if (wb_valid !== 1'b0) $display("FAIL single_popped got %b want 0", wb_valid); else pass_cnt++;
   endtask

   task automatic test_full_order();
      wb_ready = 1'b0;
      drive(1'b1, 5'd1, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 5'd2, 32'd20, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", in_ready); else pass_cnt++;
      drive(1'b1, 5'd4, 32'd30, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      total_cnt++; if (in_ready !== 1'b0 || wb_data !== 32'd10)
         $display("FAIL full_blocked got rdy=%b d=%0d want rdy=0 d=10", in_ready, wb_data); else pass_cnt++;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      wb_ready = 1'b1;
      #1;
      total_cnt++; if (wb_data !== 32'd10 || wb_rd !== 5'd1)
         $display("FAIL full_pop1 got d=%0d rd=%0d want d=10 rd=1", wb_data, wb_rd); else pass_cnt++;
      cyc();
      total_cnt++; if (wb_data !== 32'd20 || wb_rd !== 5'd2)
         $display("FAIL full_pop2 got d=%0d rd=%0d want d=20 rd=2", wb_data, wb_rd); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL full_ready_back got %b want 1", in_ready); else pass_cnt++;
      cyc();
      wb_ready = 1'b0;
      total_cnt++; if (wb_valid !== 1'b0) $display("FAIL full_third_dropped got %b want 0", wb_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      wb_ready = 1'b0;
      drive(1'b1, 5'd7, 32'd100, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      wb_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 5'(8 + i), 32'(101 + i), 1'b1, 1'b0, 1'b0, 1'b0);
         #1;
         total_cnt++; if (wb_valid !== 1'b1 || in_ready !== 1'b1 || wb_data !== 32'(100 + i))
            $display("FAIL b2b_%0d got v=%b rdy=%b d=%0d want v=1 rdy=1 d=%0d",
                     i, wb_valid, in_ready, wb_data, 100 + i);
         else pass_cnt++;
         cyc();
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      total_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'd108 || wb_rd !== 5'd15)
         $display("FAIL b2b_last got v=%b d=%0d rd=%0d want v=1 d=108 rd=15", wb_valid, wb_data, wb_rd);
      else pass_cnt++;
      cyc();
      wb_ready = 1'b0;
      total_cnt++; if (wb_valid !== 1'b0) $display("FAIL b2b_drained got %b want 0", wb_valid); else pass_cnt++;
   endtask

   task automatic test_flags();
      drive(1'b1, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      br_cond = 3'd2; #1;
      total_cnt++; if (br_taken !== 1'b1) $display("FAIL flags_bz got %b want 1", br_taken); else pass_cnt++;
      total_cnt++; if (wb_valid !== 1'b0) $display("FAIL flags_no_push got %b want 0", wb_valid); else pass_cnt++;
      drive(1'b1, 5'd0, 32'hFFFF_FFC0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      br_cond = 3'd6; #1;
      total_cnt++; if (br_taken !== 1'b1) $display("FAIL flags_bltz got %b want 1", br_taken); else pass_cnt++;
      br_cond = 3'd7; #1;
      total_cnt++; if (br_taken !== 1'b0) $display("FAIL flags_bgtz got %b want 0", br_taken); else pass_cnt++;
      br_cond = 3'd3; #1;
      total_cnt++; if (br_taken !== 1'b1) $display("FAIL flags_bnz got %b want 1", br_taken); else pass_cnt++;
      br_cond = 3'd5; #1;
      total_cnt++; if (br_taken !== 1'b1) $display("FAIL flags_bncy got %b want 1", br_taken); else pass_cnt++;
      drive(1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++; if ({flag_carry, flag_zero, flag_sign} !== 3'b001)
         $display("FAIL flags_hold got %b want 001", {flag_carry, flag_zero, flag_sign}); else pass_cnt++;
   endtask

   task automatic test_flag_fwd();
      logic exp_now;
`ifdef FLAG_FWD_EN
      exp_now = 1'b1;
`else
      exp_now = 1'b0;
`endif
      br_cond = 3'd4;
      drive(1'b1, 5'd0, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      total_cnt++; if (br_taken !== exp_now) $display("FAIL fwd_same_cycle got %b want %b", br_taken, exp_now); else pass_cnt++;
      cyc();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (br_taken !== 1'b1) $display("FAIL fwd_next_cycle got %b want 1", br_taken); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      wb_ready = 1'b0;
      drive(1'b1, 5'd9, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
      cyc();
      drive(1'b1, 5'd10, 32'd55, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      total_cnt++; if (wb_valid !== 1'b1 || in_ready !== 1'b0 || {flag_carry, flag_zero, flag_sign} !== 3'b111)
         $display("FAIL arst_pre got v=%b rdy=%b f=%b want v=1 rdy=0 f=111",
                  wb_valid, in_ready, {flag_carry, flag_zero, flag_sign});
      else pass_cnt++;
      #1 rst_n = 1'b0;
      #1;
      total_cnt++; if (wb_valid !== 1'b0 || in_ready !== 1'b1 || {flag_carry, flag_zero, flag_sign} !== 3'b000)
         $display("FAIL arst_now got v=%b rdy=%b f=%b want v=0 rdy=1 f=000",
                  wb_valid, in_ready, {flag_carry, flag_zero, flag_sign});
      else pass_cnt++;
      #1 rst_n = 1'b1;
      cyc();
      total_cnt++; if (wb_valid !== 1'b0) $display("FAIL arst_discard got %b want 0", wb_valid); else pass_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      wb_ready = 1'b0;
      br_cond = 3'd0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      test_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      test_single_hold();
      test_full_order();
      test_back_to_back();
      test_flags();
      test_flag_fwd();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
